// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundle between N byte-stream requesters, the arbiter
// and one uart_tx transmitter.
//   req_valid/req_data/req_last : per-requester byte offer (requester side)
//   req_ack                     : one-hot consume pulse (arbiter side)
//   tx_data/tx_start            : byte and start pulse towards uart_tx
//   tx_ready                    : uart_tx idle
//   busy/grant_id               : arbiter status
// Modports: master = arbiter, slave = requesters + transmitter environment.
interface uart_tx_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_ready;
  logic           busy;
  logic [IDW-1:0] grant_id;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ack, tx_data, tx_start, busy, grant_id
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ack, tx_data, tx_start, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between N byte-stream requesters.
// Picks the next requester round-robin, forwards one byte at a time on
// tx_data/tx_start, waits for the transmitter to go busy and idle again,
// and pulses req_ack for each consumed byte.
// Ports:
//   clk      : system clock
//   rstn     : synchronous active-low reset
//   bus      : uart_tx_arbiter_if.master (requester offers, req_ack,
//              tx_data/tx_start/tx_ready, busy, grant_id)
// Build option: define UART_ARB_MSG_LOCK_EN to hold the grant until a byte
// flagged with req_last has been sent (no message interleaving). Without it
// req_last is ignored and every byte is arbitrated on its own.
module uart_tx_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic               clk,
  input  logic               rstn,
  uart_tx_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] last_ptr;
  logic [IDW-1:0] grant_q;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic           any_valid;
  logic           accept;
  logic           cont;
  logic [7:0]     sel_byte;
  logic [7:0]     tx_data_q;
  logic           tx_start_q;

`ifdef UART_ARB_MSG_LOCK_EN
  logic           last_flag;
  assign cont = !last_flag;
`else
  assign cont = 1'b0;
`endif

  // Rotating search starting just after the last owner.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IDW'((32'(last_ptr) + k) % N);
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  assign sel_byte = bus.req_data[{grant_q, 3'b000} +: 8];

  // Gated with rstn so a byte is never consumed in a cycle whose start
  // pulse the reset is about to discard.
  assign accept = rstn && (state == SEND) && bus.tx_ready && bus.req_valid[grant_q];

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (any_valid)     state_nxt = SEND;
      SEND:      if (accept)        state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!bus.tx_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.tx_ready)  state_nxt = cont ? SEND : IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_ptr   <= IDW'(N - 1);
      grant_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef UART_ARB_MSG_LOCK_EN
      last_flag  <= 1'b0;
`endif
    end else begin
      tx_start_q <= accept;
      if (state == IDLE && any_valid) grant_q <= winner;
      if (accept) begin
        tx_data_q <= sel_byte;
`ifdef UART_ARB_MSG_LOCK_EN
        last_flag <= bus.req_last[grant_q];
`endif
      end
      if (state == WAIT_DONE && bus.tx_ready && !cont) last_ptr <= grant_q;
    end
  end

  always_comb begin
    bus.req_ack  = accept ? ({{(N-1){1'b0}}, 1'b1} << grant_q) : '0;
    bus.busy     = (state != IDLE);
    bus.tx_data  = tx_data_q;
    bus.tx_start = tx_start_q;
    bus.grant_id = grant_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: bench for uart_tx_arbiter with queue-based requester
// models, a fixed-frame transmitter model driving tx_ready, and an
// order model computed from the round-robin rules. Honours
// UART_ARB_MSG_LOCK_EN the same way the design does.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int DW  = 8 * N;
`ifdef UART_ARB_MSG_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N), .IDW(IDW)) bus ();
  uart_tx_arbiter #(.N(N), .IDW(IDW)) dut (.clk(clk), .rstn(rstn), .bus(bus.master));

  typedef struct {
    int         prior;
    logic [3:0] mask;
    int         exp;
  } vec_t;
  vec_t tbl[10];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rq[N][$];            // entries: {last, byte}
  bit hold[N];
  bit stall    = 1'b0;
  int tx_cnt   = 0;
  int frame    = 10;
  int log_q[$];            // acks: {req, byte}
  int exp_q[$];
  int n_start  = 0;
  bit ack_prev = 1'b0;
  int ack_byte_prev = 0;
  bit ack_last_prev = 1'b0;
  bit gap_chk = 1'b0, have_prev = 1'b0, prev_last = 1'b0;
  int prev_start = 0;
  int mdl_last = N - 1;

  logic [N-1:0]   s_ack;
  logic           s_start, s_busy, s_ready, s_rstn;
  logic [7:0]     s_data;
  logic [IDW-1:0] s_gid;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(int i, int b, bit l);
    rq[i].push_back((int'(l) << 8) | (b & 255));
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cycle();
    logic [N-1:0]  v, l;
    logic [DW-1:0] d;
    int who, n1, ent;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() != 0) begin
        ent = rq[i][0];
        if (!hold[i]) v |= N'(1) << i;
        if (((ent >> 8) & 1) != 0) l |= N'(1) << i;
        d |= DW'(ent & 255) << (8 * i);
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.tx_ready  = !stall && (tx_cnt == 0);
    @(negedge clk);
    s_ack = bus.req_ack; s_start = bus.tx_start; s_data = bus.tx_data;
    s_busy = bus.busy; s_gid = bus.grant_id; s_ready = bus.tx_ready; s_rstn = rstn;
    who = -1; n1 = 0;
    for (int i = 0; i < N; i++) if (((s_ack >> i) & 1) != 0) begin who = i; n1++; end
    if (n1 != 0) begin
      check("ack_onehot", n1, 1);
      check("ack_needs_ready", int'(s_ready), 1);
      check("ack_needs_valid", int'((v >> who) & 1), 1);
      check("ack_owner", int'(s_gid), who);
      log_q.push_back((who << 8) | (rq[who][0] & 255));
    end
    check("start_one_cycle_after_ack", int'(s_start), int'(ack_prev));
    if (s_start) begin
      check("start_data", int'(s_data), ack_byte_prev);
      if (gap_chk && have_prev)
        check("start_gap", cyc - prev_start, frame + ((LOCK && !prev_last) ? 3 : 4));
      have_prev = 1'b1; prev_start = cyc; prev_last = ack_last_prev;
      n_start++;
    end
    @(posedge clk);
    #1;
    if (who >= 0) begin
      ack_byte_prev = rq[who][0] & 255;
      ack_last_prev = ((rq[who][0] >> 8) & 1) != 0;
      void'(rq[who].pop_front());
    end
    ack_prev = (who >= 0) && s_rstn;
    if (s_start) tx_cnt = frame;
    else if (tx_cnt > 0) tx_cnt--;
    cyc++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    have_prev = 1'b0;
    mdl_last = N - 1;
  endtask

  task automatic drain(string nm);
    int k = 0;
    do begin cycle(); k++; end while ((pending() || s_busy) && k < 5000);
    checks++;
    if (pending() || s_busy) begin
      failures++;
      $display("FAIL %s drain timeout: busy=%0d queued=%0d", nm, s_busy, pending());
    end
  endtask

  task automatic run_until_log(int n, string nm);
    int k = 0;
    while (log_q.size() < n && k < 2000) begin cycle(); k++; end
    checks++;
    if (log_q.size() < n) begin
      failures++;
      $display("FAIL %s ack timeout: got %0d acks expected %0d", nm, log_q.size(), n);
    end
  endtask

  task automatic run_until_starts(int n, string nm);
    int k = 0;
    while (n_start < n && k < 2000) begin cycle(); k++; end
    checks++;
    if (n_start < n) begin
      failures++;
      $display("FAIL %s start timeout: got %0d starts expected %0d", nm, n_start, n);
    end
  endtask

  task automatic wait_ready(bit lvl, string nm);
    int k = 0;
    do begin cycle(); k++; end while (s_ready != lvl && k < 2000);
    check(nm, int'(s_ready), int'(lvl));
  endtask

  task automatic compare_log(string nm);
    check({nm, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) check(nm, log_q[i], exp_q[i]);
  endtask

  // Expected byte order from the round-robin rules, all queues offered at once.
  task automatic model_order();
    int c[N][$];
    int w, ent, idx;
    for (int i = 0; i < N; i++) c[i] = rq[i];
    exp_q.delete();
    while (1) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (mdl_last + k) % N;
        if (w < 0 && c[idx].size() != 0) w = idx;
      end
      if (w < 0) break;
      do begin
        ent = c[w].pop_front();
        exp_q.push_back((w << 8) | (ent & 255));
      end while (LOCK && ((ent >> 8) & 1) == 0 && c[w].size() != 0);
      mdl_last = w;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int nmsg, nb;
    tbl[0] = '{-1, 4'b0110, 1};
    tbl[1] = '{-1, 4'b1111, 0};
    tbl[2] = '{ 1, 4'b0110, 2};
    tbl[3] = '{ 2, 4'b1011, 3};
    tbl[4] = '{ 3, 4'b0011, 0};
    tbl[5] = '{ 1, 4'b0001, 0};
    tbl[6] = '{ 0, 4'b0001, 0};
    tbl[7] = '{ 3, 4'b1000, 3};
    tbl[8] = '{ 0, 4'b1110, 1};
    tbl[9] = '{ 2, 4'b0011, 0};
    for (int i = 0; i < N; i++) hold[i] = 1'b0;

    // Reset state
    do_reset();
    cycle();
    check("rst_busy", int'(s_busy), 0);
    check("rst_start", int'(s_start), 0);
    check("rst_ack", int'(s_ack), 0);
    check("rst_grant", int'(s_gid), 0);
    check("rst_data", int'(s_data), 0);

    // Single requester "Hi\n"
    log_q.delete(); n_start = 0;
    push(0, 'h48, 0); push(0, 'h69, 0); push(0, 'h0A, 1);
    run_until_starts(3, "hi_starts");
    wait_ready(1'b0, "hi_ready_low");
    wait_ready(1'b1, "hi_ready_high");
    check("hi_busy_at_rise", int'(s_busy), 1);
    cycle();
    check("hi_busy_after_rise", int'(s_busy), 0);
    exp_q = '{'h048, 'h069, 'h00A};
    compare_log("hi_order");

    // Round-robin from reset, then 1 and 3 together
    do_reset(); log_q.delete();
    push(1, 'h11, 0); push(1, 'h12, 1); push(2, 'h21, 0); push(2, 'h22, 1);
    drain("rr1");
`ifdef UART_ARB_MSG_LOCK_EN
    exp_q = '{'h111, 'h112, 'h221, 'h222};
`else
    exp_q = '{'h111, 'h221, 'h112, 'h222};
`endif
    compare_log("rr1_order");
    log_q.delete();
    push(1, 'h13, 0); push(1, 'h14, 1); push(3, 'h31, 0); push(3, 'h32, 1);
    drain("rr2");
`ifdef UART_ARB_MSG_LOCK_EN
    exp_q = '{'h331, 'h332, 'h113, 'h114};
`else
    exp_q = '{'h331, 'h113, 'h332, 'h114};
`endif
    compare_log("rr2_order");

`ifdef UART_ARB_MSG_LOCK_EN
    // Owner drops valid mid-message while requester 3 waits
    do_reset(); log_q.delete();
    push(0, 'h0A, 0); push(0, 'h0B, 0); push(0, 'h0C, 1);
    run_until_log(1, "hold_first");
    hold[0] = 1'b1;
    push(3, 'h3A, 1);
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("hold_grant", int'(s_gid), 0);
      check("hold_no_ack", int'(s_ack), 0);
    end
    hold[0] = 1'b0;
    drain("hold");
    exp_q = '{'h00A, 'h00B, 'h00C, 'h33A};
    compare_log("hold_order");
`else
    // Byte-by-byte interleave of two 3-byte messages
    do_reset(); log_q.delete();
    push(0, 'h0A, 0); push(0, 'h0B, 0); push(0, 'h0C, 1);
    push(1, 'h1A, 0); push(1, 'h1B, 0); push(1, 'h1C, 1);
    drain("ilv");
    exp_q = '{'h00A, 'h11A, 'h00B, 'h11B, 'h00C, 'h11C};
    compare_log("ilv_order");
`endif

    // Transmitter stall
    do_reset(); log_q.delete(); n_start = 0;
    stall = 1'b1;
    push(1, 'h5A, 1);
    for (int i = 0; i < 50; i++) begin
      cycle();
      check("stall_no_ack", int'(s_ack), 0);
      check("stall_no_start", int'(s_start), 0);
    end
    check("stall_busy", int'(s_busy), 1);
    check("stall_grant", int'(s_gid), 1);
    stall = 1'b0;
    cycle();
    check("stall_ack_on_rise", int'(s_ack), 2);
    cycle();
    check("stall_start_next", int'(s_start), 1);
    check("stall_data", int'(s_data), 'h5A);
    drain("stall");

    // Reset during WAIT_BUSY
    do_reset(); log_q.delete(); n_start = 0;
    push(2, 'h2A, 0); push(2, 'h2B, 1);
    run_until_starts(1, "mid_first_start");
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    have_prev = 1'b0;
    push(0, 'h0D, 1);
    log_q.delete();
    cycle();
    check("mid_rst_busy", int'(s_busy), 0);
    check("mid_rst_start", int'(s_start), 0);
    check("mid_rst_ack", int'(s_ack), 0);
    check("mid_rst_grant", int'(s_gid), 0);
    check("mid_rst_data", int'(s_data), 0);
    run_until_log(1, "mid_after");
    if (log_q.size() != 0) check("mid_first_winner", log_q[0] >> 8, 0);
    drain("mid");

    // Table: pointer after one prior byte, then a valid pattern
    foreach (tbl[t]) begin
      do_reset();
      if (tbl[t].prior >= 0) begin
        push(tbl[t].prior, 'hE0 | tbl[t].prior, 1);
        drain("tbl_prior");
      end
      log_q.delete();
      for (int i = 0; i < N; i++) if (tbl[t].mask[i]) push(i, 'hC0 | i, 1);
      run_until_log(1, "tbl_first");
      if (log_q.size() != 0) check($sformatf("tbl%0d_winner", t), log_q[0] >> 8, tbl[t].exp);
      drain("tbl");
    end

    // Randomized traffic against the order model, with frame-gap timing
    for (int r = 0; r < 12; r++) begin
      frame = $urandom_range(1, 12);
      do_reset(); log_q.delete();
      for (int i = 0; i < N; i++) begin
        nmsg = $urandom_range(0, 3);
        for (int m = 0; m < nmsg; m++) begin
          nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) push(i, $urandom_range(0, 255), b == nb - 1);
        end
      end
      model_order();
      gap_chk = 1'b1;
      drain("rand");
      gap_chk = 1'b0;
      compare_log($sformatf("rand%0d_order", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` serial transmitter between N byte-stream requesters, such as a message generator, a status reporter and a debug dumper. It picks the next requester round-robin, forwards bytes one at a time to the transmitter's `data`/`start`/`ready` interface, and acknowledges each consumed byte back to its source. It sits between the requesters and the `uart_tx` instance, in place of a single-source sequencing controller.

## Interface
- `N`, 4: number of requesters, 2..8.
- `IDW`, 2: width of `grant_id`; must satisfy 2^IDW >= N.
- `clk`  in  1: system clock.
- `rstn`  in  1: reset, synchronous, active-low.
- `req_valid`  in  N: requester i has a byte on `req_data[8*i+7:8*i]`.
- `req_data`  in  8*N: packed bytes; held stable by each source until acked.
- `req_last`  in  N: the current byte of requester i ends its message.
- `req_ack`  out  N: one-hot, one-cycle pulse; that requester's byte is consumed at this edge.
- `tx_data`  out  8: byte to `uart_tx`; registered.
- `tx_start`  out  1: one-cycle start pulse to `uart_tx`; registered.
- `tx_ready`  in  1: `uart_tx` is idle and can accept a byte.
- `busy`  out  1: state is not IDLE.
- `grant_id`  out  IDW: index of the current owner; valid while `busy` is 1.

## Operation
- **States:** IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- **Reset values:**
  - state = IDLE; all outputs 0.
  - Round-robin pointer `last` = N-1, so requester 0 has top priority after reset.
- **IDLE:**
  - If any `req_valid` is 1, the winner is the first set bit searching `last+1, last+2, …`, wrapping modulo N.
  - `grant_id` <= winner; go to SEND.
- **SEND:**
  - If `tx_ready`=1 and `req_valid[grant_id]`=1:
    - `req_ack[grant_id]`=1 combinationally in this cycle.
    - `tx_data` <= that requester's byte; `tx_start` <= 1.
    - Capture `req_last[grant_id]` into `last_flag`.
    - Go to WAIT_BUSY.
  - Otherwise remain in SEND.
- **WAIT_BUSY:** `tx_start` returns to 0 after exactly one cycle. Remain until `tx_ready`=0, then go to WAIT_DONE.
- **WAIT_DONE:** remain until `tx_ready`=1, then:
  - if message lock is active and `last_flag`=0, go to SEND with the same grant;
  - otherwise set `last` <= `grant_id` and go to IDLE.
- **Fairness:** requesters whose `req_valid` is low are skipped. A requester that wins repeatedly will not win again while another requester is valid.
- **Valid drop under lock:** if the owner drops `req_valid` mid-message, the arbiter waits in SEND indefinitely. The owner keeps the grant and no other requester is served.
- **Ack timing:** a requester changes its data only after its ack edge. `req_valid` asserted in the same cycle as an ack refers to the next byte.
- **Reset mid-operation:** takes effect at the next edge whatever the state.
  - Outputs clear and the state returns to IDLE.
  - A pending `tx_start` is never issued; a byte already inside `uart_tx` finishes on its own.
- `tx_data` holds its last value between bytes.

## Timing
- IDLE→SEND takes 1 cycle after any `req_valid` is seen.
- For a byte accepted in SEND at cycle T:
  - `req_ack` is high in cycle T;
  - `tx_start` and `tx_data` are valid in cycle T+1 only.
- The arbiter never issues `tx_start` unless `tx_ready`=1 was seen in the accepting cycle.
- The WAIT_BUSY/WAIT_DONE handshake prevents a second start before the transmitter has taken the first byte and finished it.
- Minimum gap between locked bytes: the `uart_tx` frame time plus 2 cycles (WAIT_DONE→SEND, then SEND→`tx_start`).
- Between messages, add 1 cycle for IDLE.

## Configuration
- **`UART_ARB_MSG_LOCK_EN` defined:**
  - the grant is held from the first byte until a byte with `req_last`=1 has been sent;
  - messages are never interleaved.
- **Not defined:**
  - `req_last` is ignored; each byte is its own arbitration unit;
  - WAIT_DONE always returns to IDLE and the pointer advances;
  - concurrent messages interleave byte-by-byte round-robin.

## Test plan
- **Single requester, lock on:** requester 0 sends "Hi\n" (0x48, 0x69, 0x0A, last on 0x0A) with `tx_ready` modelled by a 10-cycle-busy transmitter. Expect:
  - three `tx_start` pulses with `tx_data` = 0x48, 0x69, 0x0A;
  - three `req_ack[0]` pulses;
  - `busy` falls 1 cycle after the final `tx_ready` rise.
- **Round-robin, lock on:** requesters 1 and 2 both assert 2-byte messages in the same cycle from reset. Expect all of requester 1's message, then all of requester 2's. A following request from 1 and 3 together is served 3 first.
- **Lock hold, lock on:** requester 0 is mid-message and drops valid for 20 cycles while requester 3 is valid. Expect no ack to 3 and `grant_id`=0 throughout; requester 0 resumes and finishes before 3 is served.
- **Interleave, lock off:** requesters 0 and 1 each send 3 bytes. Expect `tx_data` order 0a, 1a, 0b, 1b, 0c, 1c.
- **Transmitter stall:** `tx_ready` is held at 0 for 50 cycles while a request is pending. Expect the arbiter to stay in SEND with no `tx_start` and no ack; the byte goes out exactly 1 cycle after `tx_ready` rises.
- **Reset mid-message:** `rstn`=0 for 1 cycle during WAIT_BUSY. Expect on the next edge:
  - `busy`, `tx_start`, `req_ack`, `grant_id` all 0;
  - the subsequent arbitration grants requester 0 first.
